// File: rtl/mux_arb.sv
// mux_arb: N-channel valid/ready multiplexer with a single registered output
// stage. Arbitration is either fixed priority (lowest index wins) or
// round-robin (search starts at the channel after the last one served).
// in_ready is combinational so a drain and a fresh load share one edge.
module mux_arb #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int MODE     = 0,
    localparam int CW      = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [CW-1:0]             out_channel,
    input  logic                      out_ready
);

    logic              out_valid_r;
    logic [WIDTH-1:0]  out_data_r;
    logic [CW-1:0]     out_channel_r;
    logic [CW-1:0]     ptr_r;

    logic [CW-1:0]       start_s;
    logic [CW-1:0]       grant_s;
    logic [CW-1:0]       next_ptr_s;
    logic                found_s;
    logic                load_s;
    logic [CHANNELS-1:0] in_ready_s;
    logic [WIDTH-1:0]    sel_data_s;
    int                  idx_v;

    // Search origin: always channel 0 for fixed priority, the pointer otherwise.
    always_comb begin
        start_s = '0;
        if (MODE == 1) begin
            start_s = ptr_r;
        end else begin
            start_s = '0;
        end
    end

    // Find the first requesting channel from the search origin, with wrap.
    always_comb begin
        grant_s = '0;
        found_s = 1'b0;
        idx_v   = 0;
        for (int k = 0; k < CHANNELS; k++) begin
            idx_v = int'(start_s) + k;
            if (idx_v >= CHANNELS) begin
                idx_v = idx_v - CHANNELS;
            end else begin
                idx_v = idx_v;
            end
            if (!found_s && in_valid[idx_v]) begin
                found_s = 1'b1;
                grant_s = CW'(idx_v);
            end else begin
                found_s = found_s;
            end
        end
    end

    // The output stage accepts a word when it is empty or draining; never in reset.
    always_comb begin
        load_s = 1'b0;
        if (reset) begin
            load_s = 1'b0;
        end else begin
            load_s = (!out_valid_r || out_ready) && found_s;
        end
    end

    // One-hot accept toward the granted channel only on a load cycle.
    always_comb begin
        in_ready_s = '0;
        if (load_s) begin
            in_ready_s[grant_s] = 1'b1;
        end else begin
            in_ready_s = '0;
        end
    end

    // Pointer advances to the channel just after the one granted, wrapping.
    always_comb begin
        next_ptr_s = '0;
        if (grant_s == CW'(CHANNELS - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = grant_s + CW'(1);
        end
    end

    assign sel_data_s = in_data[int'(grant_s)*WIDTH +: WIDTH];

    // Output register and round-robin pointer update.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r   <= 1'b0;
            out_data_r    <= '0;
            out_channel_r <= '0;
            ptr_r         <= '0;
        end else if (load_s) begin
            out_valid_r   <= 1'b1;
            out_data_r    <= sel_data_s;
            out_channel_r <= grant_s;
            if (MODE == 1) begin
                ptr_r <= next_ptr_s;
            end else begin
                ptr_r <= '0;
            end
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = out_valid_r;
    assign out_data    = out_data_r;
    assign out_channel = out_channel_r;

endmodule

// File: tb/tb_mux_arb.sv
// Bench for mux_arb: four instances (fixed priority 4x32, round-robin 4x32,
// round-robin 2x8, round-robin 16x64) exercised by a vector table, directed
// multi-cycle sequences and randomized traffic against a reference model.
module tb_mux_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    int NCH [4] = '{4, 4, 2, 16};
    int WID [4] = '{32, 32, 8, 64};
    int MOD [4] = '{0, 1, 1, 1};

    logic          rst_a  [4];
    logic [15:0]   iv_a   [4];
    logic [1023:0] id_a   [4];
    logic          ordy_a [4];

    logic [15:0]   ir_a [4];
    logic          ov_a [4];
    logic [63:0]   od_a [4];
    logic [3:0]    oc_a [4];

    logic [3:0]  ir0, ir1;
    logic        ov0, ov1, ov2, ov3;
    logic [31:0] od0, od1;
    logic [1:0]  oc0, oc1;
    logic [1:0]  ir2;
    logic [7:0]  od2;
    logic [0:0]  oc2;
    logic [15:0] ir3;
    logic [63:0] od3;
    logic [3:0]  oc3;

    mux_arb #(.WIDTH(32), .CHANNELS(4), .MODE(0)) u0 (
        .clk(clk), .reset(rst_a[0]), .in_valid(iv_a[0][3:0]), .in_data(id_a[0][127:0]),
        .in_ready(ir0), .out_valid(ov0), .out_data(od0), .out_channel(oc0), .out_ready(ordy_a[0]));
    mux_arb #(.WIDTH(32), .CHANNELS(4), .MODE(1)) u1 (
        .clk(clk), .reset(rst_a[1]), .in_valid(iv_a[1][3:0]), .in_data(id_a[1][127:0]),
        .in_ready(ir1), .out_valid(ov1), .out_data(od1), .out_channel(oc1), .out_ready(ordy_a[1]));
    mux_arb #(.WIDTH(8), .CHANNELS(2), .MODE(1)) u2 (
        .clk(clk), .reset(rst_a[2]), .in_valid(iv_a[2][1:0]), .in_data(id_a[2][15:0]),
        .in_ready(ir2), .out_valid(ov2), .out_data(od2), .out_channel(oc2), .out_ready(ordy_a[2]));
    mux_arb #(.WIDTH(64), .CHANNELS(16), .MODE(1)) u3 (
        .clk(clk), .reset(rst_a[3]), .in_valid(iv_a[3]), .in_data(id_a[3]),
        .in_ready(ir3), .out_valid(ov3), .out_data(od3), .out_channel(oc3), .out_ready(ordy_a[3]));

    // Gather every instance's outputs into uniform-width arrays.
    always_comb begin
        ir_a[0] = 16'(ir0); ov_a[0] = ov0; od_a[0] = 64'(od0); oc_a[0] = 4'(oc0);
        ir_a[1] = 16'(ir1); ov_a[1] = ov1; od_a[1] = 64'(od1); oc_a[1] = 4'(oc1);
        ir_a[2] = 16'(ir2); ov_a[2] = ov2; od_a[2] = 64'(od2); oc_a[2] = 4'(oc2);
        ir_a[3] = ir3;      ov_a[3] = ov3; od_a[3] = od3;      oc_a[3] = oc3;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  iv;
        logic        ordy;
        logic [3:0]  ir;
        logic        ov;
        logic [1:0]  oc;
        logic [31:0] od;
    } vec_t;

    vec_t tbl [9];

    // Randomized traffic on instance k, checked cycle by cycle against a
    // request-level model and against a FIFO of accepted words.
    task automatic run_random(input int k, input int ncyc);
        int          nch, w, mode, m_oc, m_ptr, g, c;
        bit          m_ov, any, load, found, ordy, drain;
        logic [63:0] mask, m_od;
        logic [63:0] cur [16];
        bit          pend [16];
        int          waitl [16];
        logic [15:0] iv_v, exp_ir;
        logic [1023:0] id_v;
        logic [67:0] sb [$];
        logic [67:0] front;
        nch = NCH[k]; w = WID[k]; mode = MOD[k];
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        @(negedge clk);
        rst_a[k] = 1'b1; iv_a[k] = 16'd0; ordy_a[k] = 1'b0;
        @(posedge clk);
        m_ov = 1'b0; m_od = 64'd0; m_oc = 0; m_ptr = 0;
        for (int i = 0; i < 16; i++) begin pend[i] = 1'b0; waitl[i] = 0; cur[i] = 64'd0; end
        for (int cyc = 0; cyc < ncyc + 40; cyc++) begin
            drain = (cyc >= ncyc);
            @(negedge clk);
            rst_a[k] = 1'b0;
            for (int i = 0; i < nch; i++) begin
                if (!pend[i] && !drain && ($urandom_range(0, 1) == 1)) begin
                    pend[i] = 1'b1;
                    waitl[i] = 0;
                    cur[i] = {$urandom, $urandom} & mask;
                end
            end
            ordy = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
            iv_v = 16'd0; id_v = '0;
            for (int i = 0; i < nch; i++) begin
                iv_v[i] = pend[i];
                for (int b = 0; b < w; b++) id_v[i*w + b] = cur[i][b];
            end
            iv_a[k] = iv_v; id_a[k] = id_v; ordy_a[k] = ordy;
            #1;
            any = 1'b0;
            for (int i = 0; i < nch; i++) any = any | pend[i];
            load = (!m_ov || ordy) && any;
            g = 0; found = 1'b0;
            for (int j = 0; j < nch; j++) begin
                c = ((mode == 1 ? m_ptr : 0) + j) % nch;
                if (!found && pend[c]) begin found = 1'b1; g = c; end
            end
            exp_ir = load ? (16'd1 << g) : 16'd0;
            check("rnd_in_ready", 128'(ir_a[k]), 128'(exp_ir));
            check("rnd_out_reg", {ov_a[k], oc_a[k], od_a[k]}, {m_ov, 4'(m_oc), m_od});
            if (ov_a[k] && ordy) begin
                check("rnd_sb_nonempty", 128'(sb.size() > 0), 128'(1));
                if (sb.size() > 0) begin
                    front = sb.pop_front();
                    check("rnd_sb_order", {oc_a[k], od_a[k]}, 128'(front));
                end
            end
            if (load) begin
                if (mode == 1) check("rr_bound", 128'(waitl[g] <= nch - 1), 128'(1));
                for (int i = 0; i < nch; i++) if (i != g && pend[i]) waitl[i]++;
                waitl[g] = 0;
                sb.push_back({4'(g), cur[g]});
                m_ov = 1'b1; m_od = cur[g]; m_oc = g;
                if (mode == 1) m_ptr = (g + 1) % nch;
                pend[g] = 1'b0;
            end else if (m_ov && ordy) begin
                m_ov = 1'b0;
            end
            @(posedge clk);
        end
        check("rnd_all_delivered", 128'(sb.size()), 128'(0));
        @(negedge clk);
        iv_a[k] = 16'd0; ordy_a[k] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            rst_a[i] = 1'b1; iv_a[i] = 16'd0; id_a[i] = '0; ordy_a[i] = 1'b0;
        end
        tbl[0] = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0000_0000};
        tbl[1] = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0A0_A0A0};
        tbl[2] = '{1'b0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h1111_1111};
        tbl[3] = '{1'b0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h1111_1111};
        tbl[4] = '{1'b0, 4'b1010, 1'b0, 4'b0000, 1'b1, 2'd1, 32'h1111_1111};
        tbl[5] = '{1'b0, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 32'h3333_3333};
        tbl[6] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 32'h3333_3333};
        tbl[7] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd3, 32'h3333_3333};
        tbl[8] = '{1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 32'h2222_2222};
        id_a[0][127:0] = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hA0A0_A0A0};
        id_a[1][127:0] = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hA0A0_A0A0};
        repeat (2) @(posedge clk);

        // Fixed-priority vector table on u0, starting in reset.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            rst_a[0] = tbl[i].rst; iv_a[0] = 16'(tbl[i].iv); ordy_a[0] = tbl[i].ordy;
            #1 check("tbl_in_ready", 128'(ir_a[0]), 128'(tbl[i].ir));
            @(posedge clk); #1;
            check("tbl_out_reg", {ov_a[0], oc_a[0][1:0], od_a[0][31:0]}, {tbl[i].ov, tbl[i].oc, tbl[i].od});
        end

        // Backpressure on u0: drain, load DEADBEEF on ch2, stall 3 cycles, drain+load.
        @(negedge clk); iv_a[0] = 16'd0; ordy_a[0] = 1'b1;
        @(negedge clk); id_a[0][95:64] = 32'hDEAD_BEEF; iv_a[0] = 16'b0100; ordy_a[0] = 1'b1;
        @(posedge clk); #1 check("bp_load", {ov_a[0], od_a[0][31:0]}, {1'b1, 32'hDEAD_BEEF});
        @(negedge clk); id_a[0][95:64] = 32'hCAFE_F00D; ordy_a[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_in_ready_zero", 128'(ir_a[0]), 128'(0));
            @(posedge clk); #1;
            check("bp_hold", {ov_a[0], oc_a[0][1:0], od_a[0][31:0]}, {1'b1, 2'd2, 32'hDEAD_BEEF});
            @(negedge clk);
        end
        ordy_a[0] = 1'b1;
        #1 check("bp_release_ready", 128'(ir_a[0]), 128'(4'b0100));
        @(posedge clk); #1;
        check("bp_next_word", {ov_a[0], oc_a[0][1:0], od_a[0][31:0]}, {1'b1, 2'd2, 32'hCAFE_F00D});
        @(negedge clk); iv_a[0] = 16'd0;
        @(posedge clk); #1 check("bp_drained", 128'(ov_a[0]), 128'(0));

        // Round-robin rotation on u1 with all channels requesting.
        @(negedge clk); rst_a[1] = 1'b0;
        for (int j = 0; j < 5; j++) begin
            if (j > 0) @(negedge clk);
            iv_a[1] = 16'hF; ordy_a[1] = 1'b1;
            #1 check("rr_in_ready", 128'(ir_a[1]), 128'(4'b0001 << (j % 4)));
            @(posedge clk); #1;
            check("rr_channel", 128'(oc_a[1]), 128'(j % 4));
            check("rr_ptr", 128'(u1.ptr_r), 128'((j + 1) % 4));
        end

        // Reset mid-operation on u1: held word discarded, pointer cleared.
        @(negedge clk); iv_a[1] = 16'b0100; ordy_a[1] = 1'b0;
        @(negedge clk); rst_a[1] = 1'b1; ordy_a[1] = 1'b1;
        #1 check("rst_in_ready_zero", 128'(ir_a[1]), 128'(0));
        @(posedge clk); #1;
        check("rst_out_cleared", {ov_a[1], oc_a[1], od_a[1]}, 128'(0));
        check("rst_ptr", 128'(u1.ptr_r), 128'(0));
        @(negedge clk); rst_a[1] = 1'b0; iv_a[1] = 16'd0;
        @(posedge clk); #1 check("rst_no_replay", 128'(ov_a[1]), 128'(0));
        @(negedge clk); iv_a[1] = 16'hF;
        #1 check("rst_ch0_first", 128'(ir_a[1]), 128'(4'b0001));
        @(posedge clk);
        @(negedge clk); iv_a[1] = 16'd0;

        // Randomized traffic on every configuration.
        for (int k = 0; k < 4; k++) run_random(k, 400);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mux_arb.md
MUX_ARB -- requirements
Module: mux_arb

Interface
REQ-001 Parameter WIDTH, default 32, data width of every channel and of the output, in bits.
REQ-002 Parameter CHANNELS, default 4, number of input channels; the only legal values are 2 to 16.
REQ-003 Parameter MODE, default 0, selects the arbitration policy: 0 = fixed priority, 1 = round-robin.
REQ-004 Clk  input  1  single clock; all state updates on the rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 InValid  input  CHANNELS  per-channel request; bit i means InData slice i holds a word.
REQ-007 InData  input  CHANNELS*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 InReady  output  CHANNELS  per-channel accept; a transfer on channel i occurs when InValid[i] and InReady[i] are both 1 at a rising edge.
REQ-009 OutValid  output  1  output register holds a word.
REQ-010 OutData  output  WIDTH  registered selected word.
REQ-011 OutChannel  output  max(1,$clog2(CHANNELS))  index of the channel that supplied OutData.
REQ-012 OutReady  input  1  downstream accept; an output transfer occurs when OutValid and OutReady are both 1 at a rising edge.

Function
REQ-013 The block SHALL contain one output register stage, made up of OutValid, OutData and OutChannel.
REQ-014 Load condition: Load = (!OutValid || OutReady) && |InValid.
REQ-015 InReady SHALL be combinational: InReady[i] = Load && Grant[i]; at most one InReady bit is 1 in any cycle.
REQ-016 Fixed priority (MODE=0): Grant goes to the lowest-index channel that has InValid set.
REQ-017 Round-robin (MODE=1): Grant goes to the first channel with InValid set, searching from Ptr upward and wrapping from CHANNELS-1 to 0.
REQ-018 Ptr SHALL update to (granted index + 1) mod CHANNELS only on a cycle where Load is true; otherwise Ptr holds.
REQ-019 When MODE=0, Ptr is unused and SHALL stay at 0.
REQ-020 On Load, the next state is OutValid=1, OutData=InData[granted], OutChannel=granted index.
REQ-021 When there is no Load and OutValid && OutReady, the next state is OutValid=0; OutData and OutChannel hold their values.
REQ-022 When OutValid && !OutReady, OutData and OutChannel SHALL hold stable and every InReady bit SHALL be 0 (backpressure).
REQ-023 Latency is 1 cycle from an input transfer to OutValid=1.
REQ-024 Throughput is 1 word per cycle while OutReady=1 and at least one InValid is held.
REQ-025 Simultaneous drain and load: the output word leaves and the new word loads at the same edge, with no bubble.
REQ-026 A request with no grant SHALL remain pending; the block never drops or duplicates a word.
REQ-027 Round-robin starvation bound: a continuously asserted InValid[i] SHALL be granted within CHANNELS loads.
REQ-028 InData is sampled only at the granted slice; the other slices are don't-care.

Reset
REQ-029 While Reset=1 at a rising edge, the next state SHALL be OutValid=0, OutData=0, OutChannel=0 and Ptr=0.
REQ-030 While Reset=1, every InReady bit SHALL be 0, whatever the values of InValid and OutReady.
REQ-031 A word held in the output register when Reset asserts is discarded, and no input transfer occurs during Reset.
REQ-032 In the first cycle after Reset deasserts, the block SHALL behave as idle and empty, with channel 0 having top round-robin priority.

Verification
REQ-033 Reset check, default parameters: Reset=1, InValid=4'b1111, OutReady=1 -> InReady=0000 and OutValid=0; after release, the first edge loads channel 0 and OutChannel=0.
REQ-034 Fixed priority check, MODE=0: InValid=4'b1010, InData ch1=0x11111111, ch3=0x33333333, OutReady=1 -> OutData=0x11111111 and OutChannel=1, then ch1 repeats every cycle while it stays valid; ch3 is never served.
REQ-035 Round-robin check, MODE=1: InValid=4'b1111 held, OutReady=1 -> the OutChannel sequence is 0,1,2,3,0 and Ptr wraps from 3 to 0.
REQ-036 Backpressure check: load 0xDEADBEEF on ch2, then hold OutReady=0 for 3 cycles -> OutValid=1, OutData=0xDEADBEEF stable and InReady=0000; OutReady=1 -> the word is drained once and the next word loads at the same edge.
REQ-037 Reset mid-operation check: OutValid=1 with a word held and OutReady=0; pulse Reset for one cycle -> OutValid=0, OutData=0 and Ptr=0; the held word is never presented again.
REQ-038 Parameter sweep: CHANNELS=2 with WIDTH=8, and CHANNELS=16 with WIDTH=64; random InValid and OutReady checked against a scoreboard -> no loss, no duplication, in-order delivery per channel, and the round-robin bound of REQ-027 holds.
